// File: rtl/bus_arb.sv
// ---------------------------------------------------------------------------
// bus_arb
//
// Two-master round-robin arbiter placed directly in front of busctl. It
// serialises single-byte read/write transactions onto busctl's single
// write_en/addr_in/data_in port and routes busctl's data_out back to the
// master that issued the read once the memory read latency has elapsed.
//
// Master 0 is the CPU bus interface, master 1 is the DMA/peripheral master.
// When both request in the same IDLE cycle, the master that did not own the
// bus most recently wins. After reset master 0 wins the first tie.
//
// Parameters:
//   READ_LATENCY  cycles from the XFER cycle until bus_rdata is valid (1..7)
//   AW            address width (busctl addr_in)
//   DW            data width (busctl data_in/data_out)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   m0_req         master 0 request, held with we/addr/wdata until m0_gnt
//   m0_we          master 0 write (1) / read (0)
//   m0_addr        master 0 address
//   m0_wdata       master 0 write data
//   m0_gnt         one-cycle pulse: master 0 transaction is on the bus
//   m0_rvalid      one-cycle pulse: m0_rdata holds a fresh read result
//   m0_rdata       master 0 read data, held until its next read completes
//   m1_*           same set of signals for master 1
//   bus_write_en   to busctl write_en (high only during a write XFER cycle)
//   bus_addr       to busctl addr_in (holds last latched address)
//   bus_data       to busctl data_in (holds last latched data)
//   bus_rdata      from busctl data_out
//
// Every output comes straight from a flop, so there is no combinational
// path from any request input to any output.
// ---------------------------------------------------------------------------
module bus_arb #(
   parameter int READ_LATENCY = 1,
   parameter int AW           = 17,
   parameter int DW           = 8
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,

   output logic          bus_write_en,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_data,
   input  logic [DW-1:0] bus_rdata
);

   // The latency counter only ever holds READ_LATENCY-1, which fits in
   // three bits for the supported latency range.
   localparam int            CW       = 3;
   localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t        state;
   logic          owner;
   logic          last_owner;
   logic          xfer_we;
   logic [CW-1:0] lat_cnt;

   logic          m0_win;
   logic          m1_win;

   // Arbitration decode. A lone requester always wins; on a tie the master
   // that is not last_owner wins, which alternates the bus between the two
   // masters under continuous contention. This decode only feeds flops in
   // the state machine below, never an output directly.
   always_comb begin
      m0_win = 1'b0;
      m1_win = 1'b0;
      if (m0_req && m1_req) begin
         m0_win = last_owner;
         m1_win = !last_owner;
      end else begin
         m0_win = m0_req;
         m1_win = m1_req;
      end
   end

   // Main transaction state machine with all outputs registered.
   //
   // IDLE:   arbitrate; the winner's request is latched into the bus
   //         registers and its gnt is raised for the XFER cycle.
   // XFER:   the transaction is on the bus for exactly one cycle. Writes
   //         return to IDLE, reads start the latency countdown.
   // RDWAIT: the bus stays owned until the read data comes back, so a
   //         write from the other master can never slip in between. When
   //         the countdown hits zero, bus_rdata is captured into the
   //         owner's rdata register and its rvalid pulses next cycle.
   //
   // Pulse outputs default low every cycle so they are one cycle wide.
   // Requests seen outside IDLE are simply not looked at, which makes a
   // request dropped before its gnt a clean cancellation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= 1'b0;
         last_owner   <= 1'b1;
         xfer_we      <= 1'b0;
         lat_cnt      <= '0;
         m0_gnt       <= 1'b0;
         m1_gnt       <= 1'b0;
         m0_rvalid    <= 1'b0;
         m1_rvalid    <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         bus_write_en <= 1'b0;
         bus_addr     <= '0;
         bus_data     <= '0;
      end else begin
         m0_gnt       <= 1'b0;
         m1_gnt       <= 1'b0;
         m0_rvalid    <= 1'b0;
         m1_rvalid    <= 1'b0;
         bus_write_en <= 1'b0;

         case (state)
            IDLE: begin
               if (m0_win || m1_win) begin
                  owner      <= m1_win;
                  last_owner <= m1_win;
                  m0_gnt     <= m0_win;
                  m1_gnt     <= m1_win;
                  state      <= XFER;
                  if (m1_win) begin
                     xfer_we      <= m1_we;
                     bus_write_en <= m1_we;
                     bus_addr     <= m1_addr;
                     bus_data     <= m1_wdata;
                  end else begin
                     xfer_we      <= m0_we;
                     bus_write_en <= m0_we;
                     bus_addr     <= m0_addr;
                     bus_data     <= m0_wdata;
                  end
               end
            end

            XFER: begin
               if (xfer_we) begin
                  state <= IDLE;
               end else begin
                  lat_cnt <= LAT_LOAD;
                  state   <= RDWAIT;
               end
            end

            RDWAIT: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - CW'(1);
               end else begin
                  if (owner) begin
                     m1_rdata  <= bus_rdata;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rdata  <= bus_rdata;
                     m0_rvalid <= 1'b1;
                  end
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_bus_arb
//
// Two arbiters side by side: unit 0 with READ_LATENCY=1 and unit 1 with
// READ_LATENCY=3. Only one unit is exercised at a time. Each unit has a
// small memory model standing in for busctl, which presents read data on
// bus_rdata only in the cycle that is exactly READ_LATENCY cycles after the
// read XFER cycle.
//
// Expected bus events (gnt with bus contents, rvalid with read data) are
// pushed into a queue as stimulus is driven, each tagged with the cycle in
// which it must appear. A monitor on the falling clock edge pops and
// compares every event the DUTs produce, flags events that never showed
// up, and checks that bus_write_en is low outside write XFER cycles.
// ---------------------------------------------------------------------------
module tb_bus_arb;

   localparam int AW = 17;
   localparam int DW = 8;

   localparam int K_GNT0 = 0;
   localparam int K_GNT1 = 1;
   localparam int K_RV0  = 2;
   localparam int K_RV1  = 3;

   typedef struct {
      int            unit;
      int            kind;
      int            cycle;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;

   logic          m0_req    [2];
   logic          m0_we     [2];
   logic [AW-1:0] m0_addr   [2];
   logic [DW-1:0] m0_wdata  [2];
   logic          m0_gnt    [2];
   logic          m0_rvalid [2];
   logic [DW-1:0] m0_rdata  [2];

   logic          m1_req    [2];
   logic          m1_we     [2];
   logic [AW-1:0] m1_addr   [2];
   logic [DW-1:0] m1_wdata  [2];
   logic          m1_gnt    [2];
   logic          m1_rvalid [2];
   logic [DW-1:0] m1_rdata  [2];

   logic          bus_write_en [2];
   logic [AW-1:0] bus_addr     [2];
   logic [DW-1:0] bus_data     [2];
   logic [DW-1:0] bus_rdata    [2];

   logic [DW-1:0] mem     [2][16];
   int            rd_age  [2];
   logic [3:0]    rd_addr [2];

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t expq[$];

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   bus_arb #(.READ_LATENCY(1), .AW(AW), .DW(DW)) dut_rl1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_req       (m0_req[0]),
      .m0_we        (m0_we[0]),
      .m0_addr      (m0_addr[0]),
      .m0_wdata     (m0_wdata[0]),
      .m0_gnt       (m0_gnt[0]),
      .m0_rvalid    (m0_rvalid[0]),
      .m0_rdata     (m0_rdata[0]),
      .m1_req       (m1_req[0]),
      .m1_we        (m1_we[0]),
      .m1_addr      (m1_addr[0]),
      .m1_wdata     (m1_wdata[0]),
      .m1_gnt       (m1_gnt[0]),
      .m1_rvalid    (m1_rvalid[0]),
      .m1_rdata     (m1_rdata[0]),
      .bus_write_en (bus_write_en[0]),
      .bus_addr     (bus_addr[0]),
      .bus_data     (bus_data[0]),
      .bus_rdata    (bus_rdata[0])
   );

   bus_arb #(.READ_LATENCY(3), .AW(AW), .DW(DW)) dut_rl3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_req       (m0_req[1]),
      .m0_we        (m0_we[1]),
      .m0_addr      (m0_addr[1]),
      .m0_wdata     (m0_wdata[1]),
      .m0_gnt       (m0_gnt[1]),
      .m0_rvalid    (m0_rvalid[1]),
      .m0_rdata     (m0_rdata[1]),
      .m1_req       (m1_req[1]),
      .m1_we        (m1_we[1]),
      .m1_addr      (m1_addr[1]),
      .m1_wdata     (m1_wdata[1]),
      .m1_gnt       (m1_gnt[1]),
      .m1_rvalid    (m1_rvalid[1]),
      .m1_rdata     (m1_rdata[1]),
      .bus_write_en (bus_write_en[1]),
      .bus_addr     (bus_addr[1]),
      .bus_data     (bus_data[1]),
      .bus_rdata    (bus_rdata[1])
   );

   function automatic int rlOf(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   // Cycle counter: number of rising edges so far. Events are tagged with
   // the value this holds while they are visible.
   always @(posedge clk) cyc <= cyc + 1;

   // busctl stand-in: writes land in a 16-entry memory at the end of the
   // write XFER cycle; a read XFER starts an age counter so read data can
   // be presented only in the one cycle where it is supposed to be valid.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) begin
            rd_age[u]  <= 0;
            rd_addr[u] <= '0;
         end
      end else begin
         for (int u = 0; u < 2; u++) begin
            if (bus_write_en[u]) mem[u][bus_addr[u][3:0]] <= bus_data[u];
            if ((m0_gnt[u] || m1_gnt[u]) && !bus_write_en[u]) begin
               rd_age[u]  <= 1;
               rd_addr[u] <= bus_addr[u][3:0];
            end else if (rd_age[u] != 0 && rd_age[u] < 100) begin
               rd_age[u] <= rd_age[u] + 1;
            end
         end
      end
   end

   // Read data outside the valid cycle is a recognisable junk value.
   always_comb begin
      for (int u = 0; u < 2; u++) begin
         bus_rdata[u] = 8'hEE;
         if (rd_age[u] == rlOf(u)) bus_rdata[u] = mem[u][rd_addr[u]];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expectEvent(input int u, input int kind, input int cycle,
                              input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t e;
      e.unit  = u;
      e.kind  = kind;
      e.cycle = cycle;
      e.we    = we;
      e.addr  = addr;
      e.data  = data;
      expq.push_back(e);
   endtask

   task automatic applyStimulus(input int u, input int m, input logic req, input logic we,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (m == 0) begin
         m0_req[u] = req;  m0_we[u] = we;  m0_addr[u] = addr;  m0_wdata[u] = wdata;
      end else begin
         m1_req[u] = req;  m1_we[u] = we;  m1_addr[u] = addr;  m1_wdata[u] = wdata;
      end
   endtask

   // Step to just after the next falling edge, away from the rising edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      for (int u = 0; u < 2; u++) begin
         checkOutput($sformatf("%s_u%0d_m0_gnt", tag, u), m0_gnt[u], 0);
         checkOutput($sformatf("%s_u%0d_m1_gnt", tag, u), m1_gnt[u], 0);
         checkOutput($sformatf("%s_u%0d_m0_rvalid", tag, u), m0_rvalid[u], 0);
         checkOutput($sformatf("%s_u%0d_m1_rvalid", tag, u), m1_rvalid[u], 0);
         checkOutput($sformatf("%s_u%0d_m0_rdata", tag, u), m0_rdata[u], 0);
         checkOutput($sformatf("%s_u%0d_m1_rdata", tag, u), m1_rdata[u], 0);
         checkOutput($sformatf("%s_u%0d_bus_wen", tag, u), bus_write_en[u], 0);
         checkOutput($sformatf("%s_u%0d_bus_addr", tag, u), bus_addr[u], 0);
         checkOutput($sformatf("%s_u%0d_bus_data", tag, u), bus_data[u], 0);
      end
   endtask

   // Scoreboard monitor: retire expectations whose cycle has passed, then
   // match every gnt/rvalid seen this cycle against the queue head.
   always @(negedge clk) begin
      logic obs [4];
      exp_t e;
      while (expq.size() > 0 && expq[0].cycle < cyc) begin
         checkOutput($sformatf("missed_u%0d_k%0d", expq[0].unit, expq[0].kind), cyc, expq[0].cycle);
         void'(expq.pop_front());
      end
      for (int u = 0; u < 2; u++) begin
         obs[K_GNT0] = m0_gnt[u];
         obs[K_GNT1] = m1_gnt[u];
         obs[K_RV0]  = m0_rvalid[u];
         obs[K_RV1]  = m1_rvalid[u];
         if (!m0_gnt[u] && !m1_gnt[u])
            checkOutput($sformatf("u%0d_wen_outside_xfer", u), bus_write_en[u], 0);
         for (int k = 0; k < 4; k++) begin
            if (obs[k] === 1'b1) begin
               if (expq.size() == 0) begin
                  checkOutput($sformatf("u%0d_unexpected_event", u), k, 32'hFF);
               end else begin
                  e = expq.pop_front();
                  checkOutput($sformatf("u%0d_evt_unit", u), u, e.unit);
                  checkOutput($sformatf("u%0d_evt_kind", u), k, e.kind);
                  checkOutput($sformatf("u%0d_evt_cycle_k%0d", u, k), cyc, e.cycle);
                  if (k == K_GNT0 || k == K_GNT1) begin
                     checkOutput($sformatf("u%0d_gnt_we", u), bus_write_en[u], e.we);
                     checkOutput($sformatf("u%0d_gnt_addr", u), bus_addr[u], e.addr);
                     checkOutput($sformatf("u%0d_gnt_data", u), bus_data[u], e.data);
                  end else if (k == K_RV0) begin
                     checkOutput($sformatf("u%0d_m0_rdata", u), m0_rdata[u], e.data);
                  end else begin
                     checkOutput($sformatf("u%0d_m1_rdata", u), m1_rdata[u], e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         applyStimulus(u, 0, 0, 0, '0, '0);
         applyStimulus(u, 1, 0, 0, '0, '0);
      end
      repeat (2) tick();
      checkAllZero("reset");
      rst_n = 1'b1;
      tick();

      // Single write from m0 on unit 0.
      $display("[TB] single write");
      n = cyc;
      expectEvent(0, K_GNT0, n + 1, 1'b1, 17'h1ABCD, 8'h5A);
      applyStimulus(0, 0, 1, 1, 17'h1ABCD, 8'h5A);
      tick();
      applyStimulus(0, 0, 0, 0, '0, '0);
      tick();
      checkOutput("write_wen_after", bus_write_en[0], 0);

      // m0 stores 0xC3 at 0x00010, then m1 reads it back (latency 1).
      $display("[TB] read return, latency 1");
      n = cyc;
      expectEvent(0, K_GNT0, n + 1, 1'b1, 17'h00010, 8'hC3);
      applyStimulus(0, 0, 1, 1, 17'h00010, 8'hC3);
      tick();
      applyStimulus(0, 0, 0, 0, '0, '0);
      tick();
      n = cyc;
      expectEvent(0, K_GNT1, n + 1, 1'b0, 17'h00010, 8'h00);
      expectEvent(0, K_RV1,  n + 3, 1'b0, '0, 8'hC3);
      applyStimulus(0, 1, 1, 0, 17'h00010, 8'h00);
      tick();
      applyStimulus(0, 1, 0, 0, '0, '0);
      repeat (4) tick();
      checkOutput("read_m1_rdata_held", m1_rdata[0], 8'hC3);
      checkOutput("read_m0_rdata_untouched", m0_rdata[0], 8'h00);

      // Both masters write continuously from reset: m0, m1, m0, m1.
      $display("[TB] round robin");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n = cyc;
      expectEvent(0, K_GNT0, n + 1, 1'b1, 17'h00A01, 8'h10);
      expectEvent(0, K_GNT1, n + 3, 1'b1, 17'h00B01, 8'h20);
      expectEvent(0, K_GNT0, n + 5, 1'b1, 17'h00A02, 8'h11);
      expectEvent(0, K_GNT1, n + 7, 1'b1, 17'h00B02, 8'h21);
      applyStimulus(0, 0, 1, 1, 17'h00A01, 8'h10);
      applyStimulus(0, 1, 1, 1, 17'h00B01, 8'h20);
      tick();
      applyStimulus(0, 0, 1, 1, 17'h00A02, 8'h11);
      repeat (2) tick();
      applyStimulus(0, 1, 1, 1, 17'h00B02, 8'h21);
      repeat (4) tick();
      applyStimulus(0, 0, 0, 0, '0, '0);
      applyStimulus(0, 1, 0, 0, '0, '0);
      repeat (3) tick();

      // Unit 1 (latency 3): m0 read in flight, m1 write raised in RDWAIT.
      $display("[TB] mid-read contention, latency 3");
      n = cyc;
      expectEvent(1, K_GNT0, n + 1, 1'b1, 17'h00007, 8'h3C);
      applyStimulus(1, 0, 1, 1, 17'h00007, 8'h3C);
      tick();
      applyStimulus(1, 0, 0, 0, '0, '0);
      tick();
      n = cyc;
      expectEvent(1, K_GNT0, n + 1, 1'b0, 17'h00007, 8'h11);
      expectEvent(1, K_RV0,  n + 5, 1'b0, '0, 8'h3C);
      expectEvent(1, K_GNT1, n + 6, 1'b1, 17'h0ABCD, 8'h77);
      applyStimulus(1, 0, 1, 0, 17'h00007, 8'h11);
      tick();
      applyStimulus(1, 0, 0, 0, '0, '0);
      repeat (2) tick();
      applyStimulus(1, 1, 1, 1, 17'h0ABCD, 8'h77);
      repeat (3) tick();
      applyStimulus(1, 1, 0, 0, '0, '0);
      repeat (3) tick();
      checkOutput("contention_m0_rdata", m0_rdata[1], 8'h3C);

      // m1 pulses its request only during the XFER of an m0 write.
      $display("[TB] cancellation");
      n = cyc;
      expectEvent(1, K_GNT0, n + 1, 1'b1, 17'h00100, 8'hA5);
      applyStimulus(1, 0, 1, 1, 17'h00100, 8'hA5);
      tick();
      applyStimulus(1, 0, 0, 0, '0, '0);
      applyStimulus(1, 1, 1, 1, 17'h00200, 8'h99);
      tick();
      applyStimulus(1, 1, 0, 0, '0, '0);
      repeat (4) tick();
      checkOutput("cancel_bus_addr", bus_addr[1], 17'h00100);
      checkOutput("cancel_bus_data", bus_data[1], 8'hA5);

      // Reset while an m1 read waits for data; no rvalid may follow and
      // the first tie afterwards goes to m0.
      $display("[TB] reset mid-read");
      n = cyc;
      expectEvent(1, K_GNT1, n + 1, 1'b0, 17'h00007, 8'h00);
      applyStimulus(1, 1, 1, 0, 17'h00007, 8'h00);
      tick();
      applyStimulus(1, 1, 0, 0, '0, '0);
      tick();
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      n = cyc;
      expectEvent(1, K_GNT0, n + 1, 1'b1, 17'h00020, 8'h44);
      applyStimulus(1, 0, 1, 1, 17'h00020, 8'h44);
      applyStimulus(1, 1, 1, 1, 17'h00030, 8'h55);
      tick();
      applyStimulus(1, 0, 0, 0, '0, '0);
      applyStimulus(1, 1, 0, 0, '0, '0);
      repeat (6) tick();
      checkOutput("post_reset_m1_rdata", m1_rdata[1], 8'h00);

      tick();
      checkOutput("scoreboard_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Two-master arbiter that sits directly upstream of busctl and drives its single write_en/addr_in/data_in port.
- Master 0 is the CPU bus interface; master 1 is the DMA/peripheral master.
- Serialises single-byte read/write transactions with round-robin fairness.
- Tracks the memory read latency and returns busctl's data_out to the master that issued the read.

Parameters:
- READ_LATENCY, 1, cycles from the XFER cycle until bus_rdata is valid (legal range 1..7).
- AW, 17, address width (matches busctl addr_in).
- DW, 8, data width (matches busctl data_in/data_out).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_req  in  1  master 0 request; held high with m0_we/m0_addr/m0_wdata stable until m0_gnt.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: master 0 transaction is on the bus this cycle.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata holds master 0 read result.
- m0_rdata  out  DW  master 0 read data, held until the next master 0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- bus_write_en  out  1  to busctl write_en.
- bus_addr  out  AW  to busctl addr_in.
- bus_data  out  DW  to busctl data_in.
- bus_rdata  in  DW  from busctl data_out.

Behaviour:
- Reset: all outputs are 0; state=IDLE; last_owner=1 (master 0 wins the first tie); latency counter=0.
- All outputs are registered or decoded from registered state only. No combinational path from mX_req to any output.

FSM states IDLE, XFER, RDWAIT:
- IDLE, no req: stay in IDLE.
- IDLE, exactly one req: that master wins.
- IDLE, both req: the master != last_owner wins.
- On a win: latch the winner's we/addr/wdata into the bus registers, set owner=winner, last_owner=winner, go to XFER.
- XFER (exactly one cycle): bus_write_en=latched we; bus_addr/bus_data=latched values; mOwner_gnt=1.
  - Write: next state is IDLE.
  - Read: load counter=READ_LATENCY-1, go to RDWAIT.
- RDWAIT: bus_write_en=0.
  - Counter!=0: decrement.
  - Counter==0: capture bus_rdata into the owner's rdata register, pulse the owner's rvalid for the following cycle, go to IDLE.
- The rvalid pulse therefore appears READ_LATENCY+1 cycles after the gnt cycle.

Timing:
- Latency from req seen in IDLE to gnt: 1 cycle.
- Throughput: write, 1 transaction per 2 cycles; read, 1 per READ_LATENCY+2 cycles.

Bus signals outside XFER:
- bus_write_en=0.
- bus_addr/bus_data hold their last latched values; never X after reset.

Boundary rules:
- Requests arriving in XFER/RDWAIT wait; arbitration happens only in IDLE.
- A req dropped before gnt is a legal cancellation; nothing is issued.
- A req still high in the cycle after gnt is a new request.
- A read and a write from different masters never overlap: the bus is owned until read data returns.
- Non-owner rdata/rvalid are unaffected by the owner's transaction.
- rst_n low mid-transaction (any state): immediate return to reset values. A pending rvalid is dropped; bus_write_en goes low asynchronously.

Test Plan:
- Single write:
  - Stimulus: m0_req=1, we=1, addr=0x1ABCD, wdata=0x5A in IDLE.
  - Required: next cycle m0_gnt=1, bus_write_en=1, bus_addr=0x1ABCD, bus_data=0x5A. Following cycle: bus_write_en=0, state IDLE.
- Read return (READ_LATENCY=1):
  - Stimulus: m1 reads 0x00010 with memory holding 0xC3.
  - Required: m1_gnt at cycle T; m1_rvalid=1 with m1_rdata=0xC3 at T+2; m0_rvalid stays 0.
- Round-robin:
  - Stimulus: both masters request writes continuously from reset.
  - Required: gnt order m0, m1, m0, m1; each gnt 2 cycles apart.
- Mid-read contention:
  - Stimulus: m0 read in progress with READ_LATENCY=3; m1 raises a write req during RDWAIT.
  - Required: bus_write_en stays 0 until m0_rvalid; m1_gnt comes 1 cycle after the return to IDLE.
- Cancellation:
  - Stimulus: m1_req pulses high for 1 cycle while in XFER of an m0 write.
  - Required: no m1_gnt, no bus activity for m1.
- Reset mid-read:
  - Stimulus: assert rst_n=0 during RDWAIT.
  - Required: all outputs 0 immediately; no rvalid after release; the first tie after release goes to m0.
